// File: rtl/fetch_unit_pkg.sv
// Shared widths, reset PC and FSM encoding for the instruction-fetch stage.
package fetch_unit_pkg;

    localparam int unsigned DEF_PC_WIDTH   = 32;
    localparam int unsigned DEF_INSN_WIDTH = 32;
    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_ST_IDLE  = 2'd0,
        FETCH_ST_REQ   = 2'd1,
        FETCH_ST_HOLD  = 2'd2,
        FETCH_ST_DRAIN = 2'd3
    } fetch_st_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {PC, IR} buffer that catches a fetched instruction while ID is stalled.
module fetch_skid_buf
    import fetch_unit_pkg::*;
#(
    parameter int unsigned PC_WIDTH   = DEF_PC_WIDTH,
    parameter int unsigned INSN_WIDTH = DEF_INSN_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic                  clear_i,
    input  logic [PC_WIDTH-1:0]   pc_i,
    input  logic [INSN_WIDTH-1:0] ir_i,
    output logic                  full_o,
    output logic [PC_WIDTH-1:0]   pc_o,
    output logic [INSN_WIDTH-1:0] ir_o
);

    logic                  full_q;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [INSN_WIDTH-1:0] ir_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            pc_q   <= '0;
            ir_q   <= '0;
        end else if (clear_i) begin
            full_q <= 1'b0;
        end else if (load_i) begin
            full_q <= 1'b1;
            pc_q   <= pc_i;
            ir_q   <= ir_i;
        end
    end

    assign full_o = full_q;
    assign pc_o   = pc_q;
    assign ir_o   = ir_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, imem req/ack handshake, skid buffer and IF/ID register.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned         PC_WIDTH   = DEF_PC_WIDTH,
    parameter int unsigned         INSN_WIDTH = DEF_INSN_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(DEF_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PC_WIDTH-1:0]   NPC,
    input  logic                  redirect,
    input  logic                  stall,
    input  logic                  imem_ack,
    input  logic [INSN_WIDTH-1:0] imem_rdata,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    output logic [PC_WIDTH-1:0]   PC,
    output logic [PC_WIDTH-1:0]   PC_D,
    output logic [INSN_WIDTH-1:0] IR_D,
    output logic                  valid_D
);

    fetch_st_e             state_q;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [PC_WIDTH-1:0]   addr_q;
    logic                  req_q;
    logic [PC_WIDTH-1:0]   if_id_pc_q;
    logic [INSN_WIDTH-1:0] if_id_ir_q;
    logic                  if_id_valid_q;

    logic [PC_WIDTH-1:0]   pc_d;
    logic                  skid_load;
    logic                  skid_clear;
    logic                  skid_full;
    logic [PC_WIDTH-1:0]   skid_pc;
    logic [INSN_WIDTH-1:0] skid_ir;

    // Next PC is always loaded word-aligned.
    assign pc_d       = NPC & ~PC_WIDTH'(3);
    assign skid_load  = (state_q == FETCH_ST_REQ) && imem_ack && stall && !redirect;
    assign skid_clear = (state_q == FETCH_ST_HOLD) && (redirect || !stall);

    fetch_skid_buf #(
        .PC_WIDTH   (PC_WIDTH),
        .INSN_WIDTH (INSN_WIDTH)
    ) u_skid (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .pc_i    (pc_q),
        .ir_i    (imem_rdata),
        .full_o  (skid_full),
        .pc_o    (skid_pc),
        .ir_o    (skid_ir)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= FETCH_ST_IDLE;
            pc_q          <= RESET_PC;
            addr_q        <= RESET_PC;
            req_q         <= 1'b0;
            if_id_pc_q    <= '0;
            if_id_ir_q    <= '0;
            if_id_valid_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH_ST_IDLE: begin
                    state_q <= FETCH_ST_REQ;
                    req_q   <= 1'b1;
                    addr_q  <= pc_q;
                end
                FETCH_ST_REQ: begin
                    if (redirect) begin
                        pc_q          <= pc_d;
                        if_id_valid_q <= 1'b0;
                        if (imem_ack) begin
                            addr_q <= pc_d;
                        end else begin
                            // Request already issued at the old address; let it finish.
                            state_q <= FETCH_ST_DRAIN;
                        end
                    end else if (imem_ack) begin
                        pc_q   <= pc_d;
                        addr_q <= pc_d;
                        if (stall) begin
                            state_q <= FETCH_ST_HOLD;
                            req_q   <= 1'b0;
                        end else begin
                            if_id_pc_q    <= pc_q;
                            if_id_ir_q    <= imem_rdata;
                            if_id_valid_q <= 1'b1;
                        end
                    end else if (!stall) begin
                        if_id_valid_q <= 1'b0;
                    end
                end
                FETCH_ST_HOLD: begin
                    if (redirect) begin
                        pc_q          <= pc_d;
                        addr_q        <= pc_d;
                        if_id_valid_q <= 1'b0;
                        state_q       <= FETCH_ST_REQ;
                        req_q         <= 1'b1;
                    end else if (!stall) begin
                        if_id_pc_q    <= skid_pc;
                        if_id_ir_q    <= skid_ir;
                        if_id_valid_q <= skid_full;
                        state_q       <= FETCH_ST_REQ;
                        req_q         <= 1'b1;
                    end
                end
                FETCH_ST_DRAIN: begin
                    if (redirect) begin
                        pc_q <= pc_d;
                    end
                    if (imem_ack) begin
                        state_q <= FETCH_ST_REQ;
                        addr_q  <= redirect ? pc_d : pc_q;
                    end
                end
                default: begin
                    state_q <= FETCH_ST_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign PC        = pc_q;
    assign PC_D      = if_id_pc_q;
    assign IR_D      = if_id_ir_q;
    assign valid_D   = if_id_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: slot-level reference model checked every cycle plus literal sequence pins.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] NPC;
    logic        redirect;
    logic        stall;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] PC;
    logic [31:0] PC_D;
    logic [31:0] IR_D;
    logic        valid_D;

    fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .NPC        (NPC),
        .redirect   (redirect),
        .stall      (stall),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .PC         (PC),
        .PC_D       (PC_D),
        .IR_D       (IR_D),
        .valid_D    (valid_D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    // Reference model in terms of slots: the fetch PC, an optional stale
    // outstanding request, the IF/ID slot and the skid slot.
    bit          m_known = 1'b0;
    bit          m_started;
    logic [31:0] m_pc;
    bit          m_stale;
    logic [31:0] m_stale_addr;
    bit          m_if_v;
    bit          m_if_clean;
    logic [31:0] m_if_pc, m_if_ir;
    bit          m_sk_v;
    logic [31:0] m_sk_pc, m_sk_ir;

    always @(posedge clk) begin
        logic [31:0] tgt;
        tgt = {NPC[31:2], 2'b00};
        if (!rst_n) begin
            m_known    = 1'b1;
            m_started  = 1'b0;
            m_pc       = 32'h0;
            m_stale    = 1'b0;
            m_if_v     = 1'b0;
            m_if_clean = 1'b1;
            m_if_pc    = 32'h0;
            m_if_ir    = 32'h0;
            m_sk_v     = 1'b0;
        end else if (m_known) begin
            if (!m_started) begin
                m_started = 1'b1;
            end else if (m_sk_v) begin
                if (redirect) begin
                    m_pc   = tgt;
                    m_if_v = 1'b0;
                    m_sk_v = 1'b0;
                end else if (!stall) begin
                    m_if_v = 1'b1; m_if_clean = 1'b0;
                    m_if_pc = m_sk_pc; m_if_ir = m_sk_ir;
                    m_sk_v = 1'b0;
                end
            end else if (m_stale) begin
                if (redirect) m_pc = tgt;
                if (imem_ack) m_stale = 1'b0;
            end else if (redirect) begin
                m_if_v = 1'b0;
                if (!imem_ack) begin
                    m_stale      = 1'b1;
                    m_stale_addr = m_pc;
                end
                m_pc = tgt;
            end else if (imem_ack) begin
                if (stall) begin
                    m_sk_v = 1'b1; m_sk_pc = m_pc; m_sk_ir = mem_word(m_pc);
                end else begin
                    m_if_v = 1'b1; m_if_clean = 1'b0;
                    m_if_pc = m_pc; m_if_ir = mem_word(m_pc);
                end
                m_pc = m_pc + 32'd4;
                m_pc = tgt;
            end else if (!stall) begin
                m_if_v = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            check("req", 32'(imem_req), 32'(m_started && !m_sk_v));
            check("pc", PC, m_pc);
            check("valid_D", 32'(valid_D), 32'(m_if_v));
            if (m_started && !m_sk_v)
                check("addr", imem_addr, m_stale ? m_stale_addr : m_pc);
            if (m_if_v || m_if_clean) begin
                check("PC_D", PC_D, m_if_pc);
                check("IR_D", IR_D, m_if_ir);
            end
        end
    end

    logic [31:0] ret_pc[$];
    logic [31:0] ret_ir[$];

    // Drive one cycle of inputs (NPC acts as the next-PC logic), log what ID consumes.
    task automatic step(input bit a, input bit s, input bit r, input logic [31:0] tgt);
        imem_ack   = a;
        stall      = s;
        redirect   = r;
        NPC        = r ? tgt : m_pc + 32'd4;
        imem_rdata = a ? mem_word(imem_addr) : 32'hDEAD_BEEF;
        if (rst_n && valid_D && !s) begin
            ret_pc.push_back(PC_D);
            ret_ir.push_back(IR_D);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;
        ret_pc.delete();
        ret_ir.delete();
    endtask

    task automatic check_seq(input string name, input int n, input logic [31:0] want [8]);
        check({name, "_len"}, 32'(ret_pc.size()), 32'(n));
        for (int i = 0; i < n; i++)
            check($sformatf("%s_pc%0d", name, i), (i < ret_pc.size()) ? ret_pc[i] : 32'hBAD0_BAD1, want[i]);
    endtask

    initial begin
        rst_n = 1'b0; NPC = '0; redirect = 1'b0; stall = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0;
        @(negedge clk);
        #1;

        // Reset state
        do_reset();
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_valid", 32'(valid_D), 32'h0);
        check("rst_pc", PC, 32'h0);
        check("rst_pcd", PC_D, 32'h0);
        check("rst_ird", IR_D, 32'h0);

        // 1: ack tied high, one instruction per cycle
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("s1_lead", imem_addr - PC_D, 32'h4);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        check_seq("s1", 5, '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h0, 32'h0, 32'h0});
        check("s1_ir0", (ret_ir.size() > 0) ? ret_ir[0] : 32'hBAD0_BAD1, 32'h5A5A_0000);

        // 2: ack every third cycle
        do_reset();
        for (int i = 1; i <= 13; i++) begin
            step(i % 3 == 0, 1'b0, 1'b0, 32'h0);
            if (i == 2) check("s2_wait_addr", imem_addr, 32'h0);
        end
        check_seq("s2", 4, '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0, 32'h0, 32'h0, 32'h0});

        // 3: stall for four cycles across the ack at PC=8
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("s3_hold_req", 32'(imem_req), 32'h0);
        check("s3_hold_pcd", PC_D, 32'h4);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("s3_pcd8", PC_D, 32'h8);
        check("s3_addr", imem_addr, 32'hC);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("s3_pcdC", PC_D, 32'hC);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check_seq("s3", 4, '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0, 32'h0, 32'h0, 32'h0});

        // 4: redirect while request at 0x14 pending -> drain
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h100);
        check("s4_drain_addr", imem_addr, 32'h14);
        check("s4_drain_pc", PC, 32'h100);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("s4_drain_valid", 32'(valid_D), 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("s4_new_addr", imem_addr, 32'h100);
        check("s4_new_valid", 32'(valid_D), 32'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check_seq("s4", 8, '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h100, 32'h104, 32'h108});

        // 5: redirect and ack together
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'h200);
        check("s5_addr", imem_addr, 32'h200);
        check("s5_req", 32'(imem_req), 32'h1);
        check("s5_valid", 32'(valid_D), 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check_seq("s5", 4, '{32'h0, 32'h4, 32'h200, 32'h204, 32'h0, 32'h0, 32'h0, 32'h0});

        // 6a: reset during drain, late ack ignored
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h300);
        check("s6a_drain_addr", imem_addr, 32'h4);
        rst_n = 1'b0;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("s6a_req", 32'(imem_req), 32'h0);
        check("s6a_valid", 32'(valid_D), 32'h0);
        check("s6a_pc", PC, 32'h0);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("s6a_late_valid", 32'(valid_D), 32'h0);
        check("s6a_addr", imem_addr, 32'h0);

        // 6b: reset during hold
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("s6b_hold_req", 32'(imem_req), 32'h0);
        rst_n = 1'b0;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("s6b_req", 32'(imem_req), 32'h0);
        check("s6b_valid", 32'(valid_D), 32'h0);
        check("s6b_pc", PC, 32'h0);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("s6b_late_valid", 32'(valid_D), 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("s6b_pcd", PC_D, 32'h0);
        check("s6b_ird", IR_D, 32'h5A5A_0000);

        // 7: unaligned redirect target and PC wrap
        do_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFB);
        check("s7_align", PC, 32'hFFFF_FFF8);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check_seq("s7", 5, '{32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h0, 32'h0, 32'h0});

        // Mixed deterministic traffic, checked by the model only
        do_reset();
        for (int i = 0; i < 80; i++)
            step((i * 7) % 5 < 3, i % 4 == 1, i % 11 == 6, 32'h1000 + 32'(i) * 32'd16 + 32'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
